// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU, state and condition-select encodings for the multicycle control FSM,
// plus the packed control word that the FSM registers each cycle.
package ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_ADDI  = 5'd1;
  localparam logic [4:0] OP_SUBI  = 5'd2;
  localparam logic [4:0] OP_ANDI  = 5'd3;
  localparam logic [4:0] OP_ORI   = 5'd4;
  localparam logic [4:0] OP_LD    = 5'd8;
  localparam logic [4:0] OP_ST    = 5'd9;
  localparam logic [4:0] OP_JMP   = 5'd16;
  localparam logic [4:0] OP_BGE   = 5'd17;
  localparam logic [4:0] OP_BNE   = 5'd18;
  localparam logic [4:0] OP_BLE   = 5'd19;
  localparam logic [4:0] OP_BGEZ  = 5'd20;
  localparam logic [4:0] OP_BNZ   = 5'd21;
  localparam logic [4:0] OP_BLEZ  = 5'd22;
  localparam logic [4:0] OP_CALL  = 5'd23;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;

  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_IDLE = 4'd1;
  localparam logic [3:0] S_IF   = 4'd2;
  localparam logic [3:0] S_IR   = 4'd3;
  localparam logic [3:0] S_ID   = 4'd4;
  localparam logic [3:0] S_EX   = 4'd5;
  localparam logic [3:0] S_MEM  = 4'd6;
  localparam logic [3:0] S_LMD  = 4'd7;
  localparam logic [3:0] S_WB   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Which comparator bit steers the PC; the branch is taken when that bit is 0.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_GE   = 2'd1;
  localparam logic [1:0] SEL_NE   = 2'd2;
  localparam logic [1:0] SEL_LE   = 2'd3;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LD, CLS_ST, CLS_JMP, CLS_BR, CLS_CALL, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic       en_ins_mem, load_ir, en, read, write;
    logic       en_data_mem, wri_data_mem, ld_lmd;
    logic       ld_pc, reset_pc, reset_all;
    logic       writeport, writedata, src1, src2, selcomp, sel_pc, isbranch;
    logic [4:0] alu_func;
    logic [1:0] selsig;
    logic       sort_sel;
    logic [3:0] location;
    logic       busy, halted, err;
  } ctrl_t;

  // Quiet control word: every strobe low, R15 write path deselected.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    c.isbranch = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class, ALU function, PC-condition select.
// Zero latency; unlisted opcodes raise illegal.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [4:0] funct,
  output op_class_t  cls,
  output logic [4:0] alu_func,
  output logic [1:0] selsig,
  output logic       selcomp,
  output logic       illegal
);

  always_comb begin
    cls      = CLS_HALT;
    alu_func = ALU_ADD;
    selsig   = SEL_NONE;
    selcomp  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin cls = CLS_RTYPE; alu_func = funct;   end
      OP_ADDI:  begin cls = CLS_ITYPE; alu_func = ALU_ADD; end
      OP_SUBI:  begin cls = CLS_ITYPE; alu_func = ALU_SUB; end
      OP_ANDI:  begin cls = CLS_ITYPE; alu_func = ALU_AND; end
      OP_ORI:   begin cls = CLS_ITYPE; alu_func = ALU_OR;  end
      OP_LD:    cls = CLS_LD;
      OP_ST:    cls = CLS_ST;
      OP_JMP:   cls = CLS_JMP;
      OP_BGE:   begin cls = CLS_BR; selsig = SEL_GE; end
      OP_BNE:   begin cls = CLS_BR; selsig = SEL_NE; end
      OP_BLE:   begin cls = CLS_BR; selsig = SEL_LE; end
      OP_BGEZ:  begin cls = CLS_BR; selsig = SEL_GE; selcomp = 1'b1; end
      OP_BNZ:   begin cls = CLS_BR; selsig = SEL_NE; selcomp = 1'b1; end
      OP_BLEZ:  begin cls = CLS_BR; selsig = SEL_LE; selcomp = 1'b1; end
      OP_CALL:  cls = CLS_CALL;
      OP_HALT:  cls = CLS_HALT;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle CPU control FSM: INIT/IDLE, then IF-IR-ID-EX[-MEM[-LMD]][-WB] per instruction.
// All outputs are registered from the next state, so they line up with the state they belong to.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         out_ins,
  input  logic [2:0]          comp_res,
  input  logic [3:0]          dbg_loc,
  output logic                en_ins_mem,
  output logic                load_ir,
  output logic                en,
  output logic                read,
  output logic                write,
  output logic                en_data_mem,
  output logic                wri_data_mem,
  output logic                ld_lmd,
  output logic                ld_pc,
  output logic                resetPC,
  output logic                reset_all,
  output logic                writeport,
  output logic                writedata,
  output logic                src1,
  output logic                src2,
  output logic                selcomp,
  output logic                selPC,
  output logic                isbranch,
  output logic [4:0]          alu_func,
  output logic [1:0]          selsig,
  output logic                sort_sel,
  output logic [3:0]          location,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [RETIRE_W-1:0] retired
);

  logic [3:0] state, state_nx;
  logic       init_pulsed;
  logic [9:0] ins_q;
  logic [9:0] dec_in;
  ctrl_t      q, nx;

  op_class_t  dec_cls;
  logic [4:0] dec_alu;
  logic [1:0] dec_selsig;
  logic       dec_selcomp, dec_illegal;

  // The comparator result is consumed by the PC mux in the datapath; only opcode/funct matter here.
  logic unused_ok;
  assign unused_ok = ^{comp_res, out_ins[26:5]};

  // out_ins is only trustworthy during ID; afterwards the copy latched at the end of ID is used.
  assign dec_in = (state == S_ID) ? {out_ins[31:27], out_ins[4:0]} : ins_q;

  opcode_decoder u_dec (
    .opcode   (dec_in[9:5]),
    .funct    (dec_in[4:0]),
    .cls      (dec_cls),
    .alu_func (dec_alu),
    .selsig   (dec_selsig),
    .selcomp  (dec_selcomp),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT: if (init_pulsed) state_nx = S_IDLE;
      S_IDLE: if (start) state_nx = S_IF;
      S_IF:   state_nx = S_IR;
      S_IR:   state_nx = S_ID;
      S_ID:   state_nx = (dec_illegal || dec_cls == CLS_HALT) ? S_HALT : S_EX;
      S_EX: begin
        case (dec_cls)
          CLS_LD, CLS_ST:                state_nx = S_MEM;
          CLS_RTYPE, CLS_ITYPE, CLS_CALL: state_nx = S_WB;
          default:                       state_nx = S_IF;
        endcase
      end
      S_MEM:  state_nx = (dec_cls == CLS_LD) ? S_LMD : S_IF;
      S_LMD:  state_nx = S_WB;
      S_WB:   state_nx = S_IF;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    nx = ctrl_idle();
    case (state_nx)
      S_INIT: begin nx.reset_all = 1'b1; nx.reset_pc = 1'b1; end
      S_IF:   begin nx.busy = 1'b1; nx.en_ins_mem = 1'b1; end
      S_IR:   begin nx.busy = 1'b1; nx.load_ir = 1'b1; end
      S_ID:   begin nx.busy = 1'b1; nx.en = 1'b1; nx.read = 1'b1; end
      S_EX: begin
        nx.busy     = 1'b1;
        nx.alu_func = dec_alu;
        case (dec_cls)
          CLS_RTYPE: begin nx.src1 = 1'b1; nx.src2 = 1'b1; end
          CLS_ITYPE, CLS_LD, CLS_ST: nx.src1 = 1'b1;
          CLS_BR: begin
            nx.ld_pc   = 1'b1;
            nx.selsig  = dec_selsig;
            nx.selcomp = dec_selcomp;
          end
          default: nx.ld_pc = 1'b1;  // JMP and CALL: unconditional, selsig/selPC stay 0
        endcase
      end
      S_MEM: begin
        nx.busy        = 1'b1;
        nx.en_data_mem = 1'b1;
        if (dec_cls == CLS_ST) begin
          nx.wri_data_mem = 1'b1;
          nx.ld_pc        = 1'b1;
          nx.sel_pc       = 1'b1;
        end
      end
      S_LMD: begin nx.busy = 1'b1; nx.ld_lmd = 1'b1; end
      S_WB: begin
        nx.busy      = 1'b1;
        nx.write     = 1'b1;
        nx.writeport = (dec_cls == CLS_RTYPE);
        nx.writedata = (dec_cls != CLS_LD);
        if (dec_cls == CLS_CALL) begin
          nx.isbranch = 1'b0;  // CALL already loaded the PC in EX; WB only saves NPC to R15
        end else begin
          nx.ld_pc  = 1'b1;
          nx.sel_pc = 1'b1;
        end
      end
      S_HALT: begin
        nx.halted   = 1'b1;
        nx.sort_sel = 1'b1;
        nx.location = dbg_loc;
        nx.err      = dec_illegal;
      end
      default: nx = ctrl_idle();
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      init_pulsed <= 1'b0;
      ins_q       <= '0;
      q           <= ctrl_idle();
      retired     <= '0;
    end else begin
      state <= state_nx;
      q     <= nx;
      if (state == S_INIT) init_pulsed <= 1'b1;
      if (state == S_ID) ins_q <= {out_ins[31:27], out_ins[4:0]};
      if (q.ld_pc) retired <= retired + 1'b1;
    end
  end

  assign en_ins_mem   = q.en_ins_mem;
  assign load_ir      = q.load_ir;
  assign en           = q.en;
  assign read         = q.read;
  assign write        = q.write;
  assign en_data_mem  = q.en_data_mem;
  assign wri_data_mem = q.wri_data_mem;
  assign ld_lmd       = q.ld_lmd;
  assign ld_pc        = q.ld_pc;
  assign resetPC      = q.reset_pc;
  assign reset_all    = q.reset_all;
  assign writeport    = q.writeport;
  assign writedata    = q.writedata;
  assign src1         = q.src1;
  assign src2         = q.src2;
  assign selcomp      = q.selcomp;
  assign selPC        = q.sel_pc;
  assign isbranch     = q.isbranch;
  assign alu_func     = q.alu_func;
  assign selsig       = q.selsig;
  assign sort_sel     = q.sort_sel;
  assign location     = q.location;
  assign busy         = q.busy;
  assign halted       = q.halted;
  assign err          = q.err;

endmodule
